// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates destination tags, captures FU results, drives the CDB and retires in order.
// Optional feature: define RB_CDB_BYPASS_EN to forward accepted FU writes onto the CDB in the same cycle.
module reorder_buffer #(
  parameter int unsigned WORD_SIZE = 32,
  parameter int unsigned RB_SIZE   = 8,
  parameter int unsigned RB_INDEX  = 4,
  parameter int unsigned FU_NUM    = 4,
  parameter int unsigned REG_INDEX = 5
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          alloc_req,
  input  logic [REG_INDEX-1:0]          alloc_dest_reg,
  output logic                          alloc_ready,
  output logic [RB_INDEX-1:0]           alloc_index,
  input  logic [FU_NUM*WORD_SIZE-1:0]   data_bus,
  input  logic [FU_NUM-1:0]             valid_bus,
  input  logic [FU_NUM*RB_INDEX-1:0]    RB_index_bus,
  output logic [WORD_SIZE*RB_SIZE-1:0]  CDB_data_data,
  output logic [RB_SIZE-1:0]            CDB_data_valid,
  output logic                          commit_valid,
  output logic [RB_INDEX-1:0]           commit_index,
  output logic [REG_INDEX-1:0]          commit_reg,
  output logic [WORD_SIZE-1:0]          commit_data
);

  localparam int unsigned         CNT_W    = RB_INDEX + 1;
  localparam logic [RB_INDEX-1:0] LAST_IDX = RB_INDEX'(RB_SIZE - 1);
  localparam logic [CNT_W-1:0]    FULL_CNT = CNT_W'(RB_SIZE);

  typedef struct packed {
    logic                 busy;
    logic                 done;
    logic [REG_INDEX-1:0] dest_reg;
    logic [WORD_SIZE-1:0] value;
  } rob_entry_t;

  rob_entry_t           r_entry [RB_SIZE];
  logic [RB_INDEX-1:0]  r_head;
  logic [RB_INDEX-1:0]  r_tail;
  logic [CNT_W-1:0]     r_count;
  logic                 r_commit_valid;
  logic [RB_INDEX-1:0]  r_commit_index;
  logic [REG_INDEX-1:0] r_commit_reg;
  logic [WORD_SIZE-1:0] r_commit_data;

  logic                 w_alloc_ok;
  logic                 w_commit;
  logic [RB_SIZE-1:0]   w_wr_en;
  logic [WORD_SIZE-1:0] w_wr_data [RB_SIZE];
  rob_entry_t           w_head_entry;
  logic [RB_INDEX-1:0]  w_head_nxt;
  logic [RB_INDEX-1:0]  w_tail_nxt;
  logic [CNT_W-1:0]     w_count_nxt;

  assign alloc_ready  = (r_count < FULL_CNT);
  assign alloc_index  = r_tail;
  assign w_alloc_ok   = alloc_req && alloc_ready;

  // Per-entry writeback select; the first (lowest-numbered) FU that hits an open entry wins.
  always_comb begin
    w_wr_en = '0;
    for (int i = 0; i < RB_SIZE; i++) begin
      w_wr_data[i] = '0;
    end
    for (int i = 0; i < RB_SIZE; i++) begin
      for (int f = 0; f < FU_NUM; f++) begin
        if (!w_wr_en[i] && valid_bus[f] &&
            (RB_index_bus[f*RB_INDEX +: RB_INDEX] == RB_INDEX'(i)) &&
            r_entry[i].busy && !r_entry[i].done) begin
          w_wr_en[i]   = 1'b1;
          w_wr_data[i] = data_bus[f*WORD_SIZE +: WORD_SIZE];
        end
      end
    end
  end

  // Head entry mux and pointer/count arithmetic.
  always_comb begin
    w_head_entry = '0;
    for (int i = 0; i < RB_SIZE; i++) begin
      if (r_head == RB_INDEX'(i)) begin
        w_head_entry = r_entry[i];
      end
    end
    w_commit    = w_head_entry.busy && w_head_entry.done;
    w_head_nxt  = (r_head == LAST_IDX) ? '0 : r_head + RB_INDEX'(1);
    w_tail_nxt  = (r_tail == LAST_IDX) ? '0 : r_tail + RB_INDEX'(1);
    w_count_nxt = r_count + CNT_W'(w_alloc_ok) - CNT_W'(w_commit);
  end

  // Entry array: commit clears head, writeback completes open entries, alloc opens tail.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < RB_SIZE; i++) begin
        r_entry[i] <= '0;
      end
    end else begin
      for (int i = 0; i < RB_SIZE; i++) begin
        if (w_commit && (r_head == RB_INDEX'(i))) begin
          r_entry[i].busy <= 1'b0;
          r_entry[i].done <= 1'b0;
        end else if (w_wr_en[i]) begin
          r_entry[i].done  <= 1'b1;
          r_entry[i].value <= w_wr_data[i];
        end
        if (w_alloc_ok && (r_tail == RB_INDEX'(i))) begin
          r_entry[i].busy     <= 1'b1;
          r_entry[i].done     <= 1'b0;
          r_entry[i].dest_reg <= alloc_dest_reg;
          r_entry[i].value    <= '0;
        end
      end
    end
  end

  // Pointers, occupancy and registered commit port.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
      r_commit_valid <= 1'b0;
      r_commit_index <= '0;
      r_commit_reg   <= '0;
      r_commit_data  <= '0;
    end else begin
      r_count        <= w_count_nxt;
      r_commit_valid <= w_commit;
      if (w_alloc_ok) begin
        r_tail <= w_tail_nxt;
      end
      if (w_commit) begin
        r_head         <= w_head_nxt;
        r_commit_index <= r_head;
        r_commit_reg   <= w_head_entry.dest_reg;
        r_commit_data  <= w_head_entry.value;
      end
    end
  end

  assign commit_valid = r_commit_valid;
  assign commit_index = r_commit_index;
  assign commit_reg   = r_commit_reg;
  assign commit_data  = r_commit_data;

  // CDB view of completed, uncommitted entries.
  always_comb begin
    CDB_data_valid = '0;
    CDB_data_data  = '0;
    for (int i = 0; i < RB_SIZE; i++) begin
`ifdef RB_CDB_BYPASS_EN
      CDB_data_valid[i] = (r_entry[i].busy && r_entry[i].done) || w_wr_en[i];
      CDB_data_data[i*WORD_SIZE +: WORD_SIZE] = w_wr_en[i] ? w_wr_data[i] : r_entry[i].value;
`else
      CDB_data_valid[i] = r_entry[i].busy && r_entry[i].done;
      CDB_data_data[i*WORD_SIZE +: WORD_SIZE] = r_entry[i].value;
`endif
    end
  end

endmodule
